sp_usb_dram_bridge: RTL and testbench
=====================================

SP_USB_DRAM_BRIDGE -- requirements
Module: sp_usb_dram_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 25: line-address width, in 128-bit lines.
REQ-002 SHALL have clk  input  1: rising-edge clock for all state.
REQ-003 SHALL have rst  input  1: reset, synchronous, active-high.
REQ-004 SHALL have usb_rx_data  input  8: received byte, valid while usb_rx_avail=1.
REQ-005 SHALL have usb_rx_avail  input  1: received byte available.
REQ-006 SHALL have usb_rx_read  output  1: one-cycle pulse that consumes usb_rx_data.
REQ-007 SHALL have usb_tx_data  output  8: byte to transmit, valid with usb_tx_write.
REQ-008 SHALL have usb_tx_write  output  1: one-cycle pulse that transmits a byte.
REQ-009 SHALL have usb_tx_full  input  1: transmitter cannot accept a byte.
REQ-010 SHALL have mem_addr  output  ADDR_WIDTH: memory line address.
REQ-011 SHALL have mem_din  output  128: write data.
REQ-012 SHALL have mem_mask  output  16: byte-enable mask, 1 = write byte.
REQ-013 SHALL have mem_we  output  1: write request pulse.
REQ-014 SHALL have mem_re  output  1: read request pulse.
REQ-015 SHALL have mem_dout  input  128: read data.
REQ-016 SHALL have mem_ready  input  1: memory idle and able to accept a request.

Function
REQ-017 Host packet SHALL be: opcode byte, 4 address bytes, 2 count bytes; multi-byte fields little-endian.
- Opcode 0x01 = write; 0x02 = read.
- Line address = low ADDR_WIDTH bits of the address field.
- count = number of 128-bit lines.
REQ-018 States SHALL be: IDLE, HDR, WCOLLECT, WISSUE, RISSUE, RWAIT, RSEND, ACK.
REQ-019 usb_rx_read SHALL pulse only when usb_rx_avail=1 in IDLE, HDR or WCOLLECT, consuming at most one byte per cycle.
REQ-020 In IDLE, opcodes other than 0x01/0x02 SHALL be consumed and discarded; the block stays in IDLE.
REQ-021 After 6 header bytes in HDR: count=0 SHALL go to ACK for a write (IDLE if ACK is compiled out) and to IDLE for a read; otherwise WCOLLECT for a write, RISSUE for a read.
REQ-022 WCOLLECT SHALL pack 16 bytes, first byte into mem_din[7:0], then go to WISSUE.
REQ-023 WISSUE SHALL assert mem_we for exactly one cycle, with mem_mask=16'hFFFF and mem_addr held, in the first cycle with mem_ready=1.
REQ-024 After each line is issued, mem_addr SHALL increment by 1 (wrapping at 2^ADDR_WIDTH) and the remaining count SHALL decrement.
- Lines remaining: return to WCOLLECT (write) or RISSUE (read).
- Last line: go to ACK (write) or IDLE (read).
REQ-025 RISSUE SHALL assert mem_re for one cycle when mem_ready=1, then enter RWAIT.
REQ-026 RWAIT SHALL ignore mem_ready in the cycle immediately after mem_re, then latch mem_dout on the first cycle with mem_ready=1 and enter RSEND.
REQ-027 RSEND SHALL emit the 16 latched bytes, bits [7:0] first, pulsing usb_tx_write only in cycles with usb_tx_full=0.
REQ-028 mem_we and mem_re SHALL never be asserted in the same cycle, and each SHALL only be asserted while mem_ready=1.
REQ-029 Full count field 0xFFFF SHALL transfer 65535 lines; the 16-bit counter SHALL NOT wrap mid-transfer.
REQ-030 A stalled upstream (usb_rx_avail=0) or downstream (usb_tx_full=1) SHALL hold the current state and data indefinitely without loss.

Reset
REQ-031 On rst the block SHALL return to IDLE from any state, discarding partial packets and lines.
REQ-032 On rst: usb_rx_read, usb_tx_write, mem_we and mem_re = 0; mem_mask = 0; mem_addr = 0; count = 0; byte index = 0.
REQ-033 mem_din and the read latch SHALL not require reset values.

Configuration
REQ-034 With macro SP_USB_DRAM_ACK_EN defined, ACK SHALL send one byte 0xA5 (waiting on usb_tx_full) after every write packet, including count=0, then go to IDLE.
REQ-035 Without SP_USB_DRAM_ACK_EN, the ACK state SHALL be absent, writes SHALL finish directly to IDLE, and no byte SHALL be sent.

Verification
REQ-036 Write, addr 0x10, count 1, data bytes 0x00..0x0F -> one mem_we, mem_addr=0x10, mem_din=128'h0F0E...0100, mask FFFF; 0xA5 sent if ACK_EN.
REQ-037 Read, addr 0x1FFFFFF, count 2, model returns lines A and B -> mem_re at 0x1FFFFFF then 0x0000000; 32 bytes sent, A[7:0] first.
REQ-038 Opcode 0x7E followed by a valid write packet -> 0x7E discarded; write executes normally.
REQ-039 Read with usb_tx_full toggled every other cycle and mem_ready held low 20 cycles -> no lost or duplicated bytes, no requests while mem_ready=0.
REQ-040 rst asserted after 9 of 16 write-data bytes -> no mem_we; next packet decodes from IDLE correctly.
REQ-041 Write with count 0 -> no mem_we; 0xA5 sent only with ACK_EN.

Source files
------------

// File: rtl/sp_usb_dram_bridge.sv
// Bridges a USB byte stream to a 128-bit line memory: write/read packets of whole lines.
// Define SP_USB_DRAM_ACK_EN to send a 0xA5 acknowledge byte after every write packet.
module sp_usb_dram_bridge #(
    parameter int ADDR_WIDTH = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            usb_rx_data,
    input  logic                  usb_rx_avail,
    output logic                  usb_rx_read,
    output logic [7:0]            usb_tx_data,
    output logic                  usb_tx_write,
    input  logic                  usb_tx_full,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [127:0]          mem_din,
    output logic [15:0]           mem_mask,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [127:0]          mem_dout,
    input  logic                  mem_ready
);

    typedef enum logic [2:0] {
        IDLE, HDR, WCOLLECT, WISSUE, RISSUE, RWAIT, RSEND
`ifdef SP_USB_DRAM_ACK_EN
        , ACK
`endif
    } state_t;

`ifdef SP_USB_DRAM_ACK_EN
    localparam state_t WRITE_END = ACK;
`else
    localparam state_t WRITE_END = IDLE;
`endif

    state_t state, state_next;
    logic [3:0] byte_idx;
    logic [15:0] count;
    logic is_write;
    logic rwait_first;
    logic [127:0] rdata;
    logic [ADDR_WIDTH-1:0] addr_mask;
    logic [ADDR_WIDTH-1:0] addr_upd;

    // Header address bytes land little-endian; bits beyond ADDR_WIDTH fall off the shift.
    always_comb begin
        addr_mask = ADDR_WIDTH'(8'hFF) << {byte_idx[1:0], 3'b000};
        addr_upd = (mem_addr & ~addr_mask) | (ADDR_WIDTH'(usb_rx_data) << {byte_idx[1:0], 3'b000});
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Strobes are combinational and forced low while rst is held.
    always_comb begin
        state_next   = state;
        usb_rx_read  = 1'b0;
        usb_tx_write = 1'b0;
        usb_tx_data  = rdata[{byte_idx, 3'b000} +: 8];
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_mask     = 16'h0000;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (usb_rx_avail) begin
                        usb_rx_read = 1'b1;
                        if (usb_rx_data == 8'h01 || usb_rx_data == 8'h02) state_next = HDR;
                    end
                end
                HDR: begin
                    if (usb_rx_avail) begin
                        usb_rx_read = 1'b1;
                        if (byte_idx == 4'd5) begin
                            if ({usb_rx_data, count[7:0]} == 16'h0000)
                                state_next = is_write ? WRITE_END : IDLE;
                            else
                                state_next = is_write ? WCOLLECT : RISSUE;
                        end
                    end
                end
                WCOLLECT: begin
                    if (usb_rx_avail) begin
                        usb_rx_read = 1'b1;
                        if (byte_idx == 4'd15) state_next = WISSUE;
                    end
                end
                WISSUE: begin
                    if (mem_ready) begin
                        mem_we     = 1'b1;
                        mem_mask   = 16'hFFFF;
                        state_next = (count == 16'd1) ? WRITE_END : WCOLLECT;
                    end
                end
                RISSUE: begin
                    if (mem_ready) begin
                        mem_re     = 1'b1;
                        state_next = RWAIT;
                    end
                end
                RWAIT: begin
                    if (!rwait_first && mem_ready) state_next = RSEND;
                end
                RSEND: begin
                    if (!usb_tx_full) begin
                        usb_tx_write = 1'b1;
                        if (byte_idx == 4'd15) state_next = (count == 16'd0) ? IDLE : RISSUE;
                    end
                end
`ifdef SP_USB_DRAM_ACK_EN
                ACK: begin
                    usb_tx_data = 8'hA5;
                    if (!usb_tx_full) begin
                        usb_tx_write = 1'b1;
                        state_next   = IDLE;
                    end
                end
`endif
                default: state_next = IDLE;
            endcase
        end
    end

    // Count is decremented at issue time, so it never wraps: it only counts down to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr    <= '0;
            count       <= '0;
            byte_idx    <= '0;
            is_write    <= 1'b0;
            rwait_first <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (usb_rx_read) begin
                        is_write <= (usb_rx_data == 8'h01);
                        byte_idx <= '0;
                    end
                end
                HDR: begin
                    if (usb_rx_read) begin
                        if (byte_idx < 4'd4)       mem_addr    <= addr_upd;
                        else if (byte_idx == 4'd4) count[7:0]  <= usb_rx_data;
                        else                       count[15:8] <= usb_rx_data;
                        byte_idx <= (byte_idx == 4'd5) ? 4'd0 : byte_idx + 4'd1;
                    end
                end
                WCOLLECT: begin
                    if (usb_rx_read) byte_idx <= byte_idx + 4'd1;
                end
                WISSUE, RISSUE: begin
                    if (mem_we || mem_re) begin
                        mem_addr    <= mem_addr + ADDR_WIDTH'(1);
                        count       <= count - 16'd1;
                        rwait_first <= mem_re;
                    end
                end
                RWAIT: rwait_first <= 1'b0;
                RSEND: begin
                    if (usb_tx_write) byte_idx <= byte_idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Data registers carry no reset; they are always rewritten before use.
    always_ff @(posedge clk) begin
        if (state == WCOLLECT && usb_rx_read) mem_din[{byte_idx, 3'b000} +: 8] <= usb_rx_data;
        if (state == RWAIT && !rwait_first && mem_ready) rdata <= mem_dout;
    end

endmodule

// File: tb/tb_sp_usb_dram_bridge.sv
// Directed self-checking bench for sp_usb_dram_bridge (default and SP_USB_DRAM_ACK_EN builds).
module tb_sp_usb_dram_bridge;
    localparam int AW = 25;
`ifdef SP_USB_DRAM_ACK_EN
    localparam int ACKS = 1;
`else
    localparam int ACKS = 0;
`endif
    localparam logic [127:0] LINE_A = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [127:0] LINE_B = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] LINE_C = 128'hFEDCBA98765432100123456789ABCDEF;
    localparam logic [127:0] JUNK   = 128'hDEADDEADDEADDEADDEADDEADDEADDEAD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] usb_rx_data = 8'h00;
    logic usb_rx_avail = 1'b0;
    logic usb_rx_read;
    logic [7:0] usb_tx_data;
    logic usb_tx_write;
    logic usb_tx_full = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [127:0] mem_din;
    logic [15:0] mem_mask;
    logic mem_we;
    logic mem_re;
    logic [127:0] mem_dout = '0;
    logic mem_ready = 1'b1;

    always #5 clk = ~clk;

    sp_usb_dram_bridge #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .usb_rx_data(usb_rx_data), .usb_rx_avail(usb_rx_avail), .usb_rx_read(usb_rx_read),
        .usb_tx_data(usb_tx_data), .usb_tx_write(usb_tx_write), .usb_tx_full(usb_tx_full),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_mask(mem_mask),
        .mem_we(mem_we), .mem_re(mem_re), .mem_dout(mem_dout), .mem_ready(mem_ready)
    );

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic [AW-1:0] re_addr_q[$];
    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int bad_req = 0;
    logic [AW-1:0] last_we_addr = '0;
    logic [127:0] last_we_data = '0;
    logic [15:0] last_we_mask = '0;
    logic rx_pop = 1'b0;
    logic re_pend = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    int busy = 0;
    int ready_low = 0;
    logic tx_toggle = 1'b0;

    function automatic logic [127:0] line_at(input logic [AW-1:0] a);
        if (a == 25'h1FFFFFF) return LINE_A;
        if (a == 25'h0000000) return LINE_B;
        return LINE_C;
    endfunction

    function automatic logic [127:0] tx_line(input int base);
        logic [127:0] v = '0;
        for (int i = 0; i < 16; i++)
            if (base + i < tx_q.size()) v[i*8 +: 8] = tx_q[base + i];
        return v;
    endfunction

    // Observe DUT strobes half a cycle away from the active edge.
    always @(negedge clk) begin
        rx_pop = usb_rx_read;
        if (usb_tx_write) tx_q.push_back(usb_tx_data);
        if (usb_tx_write && usb_tx_full) bad_req++;
        if (mem_we) begin
            we_cnt++;
            last_we_addr = mem_addr;
            last_we_data = mem_din;
            last_we_mask = mem_mask;
        end
        if (mem_re) begin
            re_addr_q.push_back(mem_addr);
            re_pend   = 1'b1;
            pend_addr = mem_addr;
        end
        if ((mem_we || mem_re) && !mem_ready) bad_req++;
        if (mem_we && mem_re) bad_req++;
    end

    // Host FIFO, transmitter and memory models; memory keeps a stale ready for one cycle after a read.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rx_pop && rx_q.size() > 0) void'(rx_q.pop_front());
            rx_pop = 1'b0;
            usb_rx_avail = (rx_q.size() > 0);
            usb_rx_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
            usb_tx_full  = tx_toggle ? ~usb_tx_full : 1'b0;
            if (re_pend) begin
                re_pend  = 1'b0;
                busy     = 4;
                mem_dout = JUNK;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) mem_dout = line_at(pend_addr);
            end
            if (ready_low > 0) ready_low--;
            mem_ready = (ready_low == 0) && (busy == 0 || busy == 4);
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] opcode, input logic [31:0] addr,
                                 input logic [15:0] cnt, input logic [7:0] first, input int n);
        rx_q.push_back(opcode);
        for (int i = 0; i < 4; i++) rx_q.push_back(addr[i*8 +: 8]);
        rx_q.push_back(cnt[7:0]);
        rx_q.push_back(cnt[15:8]);
        for (int i = 0; i < n; i++) rx_q.push_back(first + 8'(i));
    endtask

    task automatic clearLog();
        tx_q.delete();
        re_addr_q.delete();
        we_cnt  = 0;
        bad_req = 0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        $display("[TB] start, ACK bytes per write = %0d", ACKS);
        rx_q.push_back(8'h7E);
        waitCycles(3);
        checkOutput("rst_strobes", {usb_rx_read, usb_tx_write, mem_we, mem_re}, 4'b0000);
        checkOutput("rst_mask", mem_mask, 16'h0000);
        checkOutput("rst_addr", mem_addr, 25'h0);
        @(posedge clk); #1; rst = 1'b0;
        waitCycles(6);
        checkOutput("junk_dropped", we_cnt + re_addr_q.size() + tx_q.size(), 0);

        // Single-line write
        clearLog();
        applyStimulus(8'h01, 32'h00000010, 16'd1, 8'h00, 16);
        waitCycles(50);
        checkOutput("w1_we_cnt", we_cnt, 1);
        checkOutput("w1_addr", last_we_addr, 25'h10);
        checkOutput("w1_data", last_we_data, 128'h0F0E0D0C0B0A09080706050403020100);
        checkOutput("w1_mask", last_we_mask, 16'hFFFF);
        checkOutput("w1_tx_cnt", tx_q.size(), ACKS);
`ifdef SP_USB_DRAM_ACK_EN
        checkOutput("w1_ack", (tx_q.size() > 0) ? tx_q[0] : 8'h00, 8'hA5);
`endif
        checkOutput("w1_next_addr", mem_addr, 25'h11);

        // Two-line read wrapping the address
        clearLog();
        applyStimulus(8'h02, 32'h01FFFFFF, 16'd2, 8'h00, 0);
        waitCycles(120);
        checkOutput("r1_re_cnt", re_addr_q.size(), 2);
        checkOutput("r1_addr0", (re_addr_q.size() > 0) ? re_addr_q[0] : 25'h0AAAAAA, 25'h1FFFFFF);
        checkOutput("r1_addr1", (re_addr_q.size() > 1) ? re_addr_q[1] : 25'h0AAAAAA, 25'h0000000);
        checkOutput("r1_tx_cnt", tx_q.size(), 32);
        checkOutput("r1_line0", tx_line(0), LINE_A);
        checkOutput("r1_line1", tx_line(16), LINE_B);
        checkOutput("r1_no_we", we_cnt, 0);
        checkOutput("r1_rules", bad_req, 0);

        // Unknown opcode, then a valid write
        clearLog();
        rx_q.push_back(8'h7E);
        applyStimulus(8'h01, 32'h00000020, 16'd1, 8'h80, 16);
        waitCycles(60);
        checkOutput("w2_we_cnt", we_cnt, 1);
        checkOutput("w2_addr", last_we_addr, 25'h20);
        checkOutput("w2_data", last_we_data, 128'h8F8E8D8C8B8A89888786858483828180);
        checkOutput("w2_tx_cnt", tx_q.size(), ACKS);

        // Read with a stalled memory and a toggling transmitter
        clearLog();
        ready_low = 20;
        tx_toggle = 1'b1;
        applyStimulus(8'h02, 32'h00000000, 16'd2, 8'h00, 0);
        waitCycles(250);
        tx_toggle = 1'b0;
        checkOutput("r2_re_cnt", re_addr_q.size(), 2);
        checkOutput("r2_addr0", (re_addr_q.size() > 0) ? re_addr_q[0] : 25'h0AAAAAA, 25'h0000000);
        checkOutput("r2_addr1", (re_addr_q.size() > 1) ? re_addr_q[1] : 25'h0AAAAAA, 25'h0000001);
        checkOutput("r2_tx_cnt", tx_q.size(), 32);
        checkOutput("r2_line0", tx_line(0), LINE_B);
        checkOutput("r2_line1", tx_line(16), LINE_C);
        checkOutput("r2_rules", bad_req, 0);

        // Reset in the middle of collecting write data
        clearLog();
        applyStimulus(8'h01, 32'h00000030, 16'd1, 8'h60, 9);
        waitCycles(30);
        checkOutput("w3_partial_we", we_cnt, 0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checkOutput("w3_rst_addr", mem_addr, 25'h0);
        applyStimulus(8'h01, 32'h00000040, 16'd1, 8'h50, 16);
        waitCycles(60);
        checkOutput("w3_we_cnt", we_cnt, 1);
        checkOutput("w3_addr", last_we_addr, 25'h40);
        checkOutput("w3_data", last_we_data, 128'h5F5E5D5C5B5A59585756555453525150);
        checkOutput("w3_tx_cnt", tx_q.size(), ACKS);

        // Zero-count write and read, then a write to prove the block is idle again
        clearLog();
        applyStimulus(8'h01, 32'h00000100, 16'd0, 8'h00, 0);
        waitCycles(20);
        checkOutput("z_write_we", we_cnt, 0);
        checkOutput("z_write_tx", tx_q.size(), ACKS);
`ifdef SP_USB_DRAM_ACK_EN
        checkOutput("z_write_ack", (tx_q.size() > 0) ? tx_q[0] : 8'h00, 8'hA5);
`endif
        clearLog();
        applyStimulus(8'h02, 32'h00000100, 16'd0, 8'h00, 0);
        applyStimulus(8'h01, 32'h00000005, 16'd1, 8'hC0, 16);
        waitCycles(60);
        checkOutput("z_read_re", re_addr_q.size(), 0);
        checkOutput("z_after_we", we_cnt, 1);
        checkOutput("z_after_addr", last_we_addr, 25'h5);
        checkOutput("z_after_data", last_we_data, 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0);
        checkOutput("z_after_tx", tx_q.size(), ACKS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
